// File: rtl/bcd_defs.sv
// Shared BCD digit limit and active-low {g..a} seven-segment patterns for the tick counter.
package bcd_defs;

    localparam logic [3:0] BCD_MAX = 4'd9;

    localparam logic [6:0] SEG_0 = 7'b1000000;
    localparam logic [6:0] SEG_1 = 7'b1111001;
    localparam logic [6:0] SEG_2 = 7'b0100100;
    localparam logic [6:0] SEG_3 = 7'b0110000;
    localparam logic [6:0] SEG_4 = 7'b0011001;
    localparam logic [6:0] SEG_5 = 7'b0010010;
    localparam logic [6:0] SEG_6 = 7'b0000010;
    localparam logic [6:0] SEG_7 = 7'b1111000;
    localparam logic [6:0] SEG_8 = 7'b0000000;
    localparam logic [6:0] SEG_9 = 7'b0010000;

    function automatic logic [6:0] seg_of(input logic [3:0] d);
        case (d)
            4'd0:    return SEG_0;
            4'd1:    return SEG_1;
            4'd2:    return SEG_2;
            4'd3:    return SEG_3;
            4'd4:    return SEG_4;
            4'd5:    return SEG_5;
            4'd6:    return SEG_6;
            4'd7:    return SEG_7;
            4'd8:    return SEG_8;
            default: return SEG_9;
        endcase
    endfunction

endpackage

// File: rtl/bcd_digit.sv
// One BCD digit with inc/dec/load/clear; wrap flags a step that rolls over wrap_at/0.
// With SEG_DECODE_EN defined, also drives a registered active-low segment pattern.
module bcd_digit (
    input  logic       CLK,
    input  logic       rst_n,
    input  logic       inc,
    input  logic       dec,
    input  logic       ld,
    input  logic       clr,
    input  logic [3:0] ld_val,
    input  logic [3:0] wrap_at,
`ifdef SEG_DECODE_EN
    output logic [6:0] seg,
`endif
    output logic [3:0] digit,
    output logic       wrap
);
`ifdef SEG_DECODE_EN
    import bcd_defs::*;
`endif

    logic [3:0] digit_nxt;

    assign wrap = (inc && digit == wrap_at) || (dec && digit == 4'd0);

    always_comb begin
        digit_nxt = digit;
        if (clr)
            digit_nxt = 4'd0;
        else if (ld)
            digit_nxt = ld_val;
        else if (inc)
            digit_nxt = wrap ? 4'd0 : digit + 4'd1;
        else if (dec)
            digit_nxt = wrap ? wrap_at : digit - 4'd1;
    end

    always_ff @(posedge CLK or negedge rst_n) begin
        if (!rst_n) begin
            digit <= 4'd0;
`ifdef SEG_DECODE_EN
            seg   <= SEG_0;
`endif
        end else begin
            digit <= digit_nxt;
`ifdef SEG_DECODE_EN
            seg   <= seg_of(digit_nxt);
`endif
        end
    end

endmodule

// File: rtl/tick_bcd_counter.sv
// Two-digit BCD up/down counter stepped by rising edges of tick_in, sampled in the CLK domain.
// Optional SEG_DECODE_EN adds registered active-low seven-segment outputs per digit.
module tick_bcd_counter #(
    parameter int MAX_TENS = 9,
    parameter int MAX_ONES = 9
) (
    input  logic       CLK,
    input  logic       rst_n,
    input  logic       tick_in,
    input  logic       en,
    input  logic       up_dn,
    input  logic       clear,
    input  logic       load,
    input  logic [7:0] load_val,
`ifdef SEG_DECODE_EN
    output logic [6:0] seg_tens,
    output logic [6:0] seg_ones,
`endif
    output logic [7:0] count,
    output logic       carry
);
    import bcd_defs::*;

    localparam logic [3:0] MT = 4'(MAX_TENS);
    localparam logic [3:0] MO = 4'(MAX_ONES);

    function automatic logic [7:0] clamp_load(input logic [7:0] v);
        logic [3:0] t;
        logic [3:0] o;
        t = (v[7:4] > BCD_MAX) ? BCD_MAX : v[7:4];
        o = (v[3:0] > BCD_MAX) ? BCD_MAX : v[3:0];
        if ({t, o} > {MT, MO})
            return {MT, MO};
        return {t, o};
    endfunction

    logic       s1, s2, s3;
    logic       step, adv;
    logic       ones_inc, ones_dec, ones_wrap;
    logic       tens_inc, tens_dec, tens_wrap;
    logic [3:0] ones, tens;
    logic [3:0] ones_wrap_at;
    logic [7:0] ld_clamped;

    // tick_in is asynchronous: two flops to synchronise, a third for the edge detect
    always_ff @(posedge CLK or negedge rst_n) begin
        if (!rst_n) begin
            s1 <= 1'b0;
            s2 <= 1'b0;
            s3 <= 1'b0;
        end else begin
            s1 <= tick_in;
            s2 <= s1;
            s3 <= s2;
        end
    end

    assign step       = s2 & ~s3;
    assign adv        = step & en & ~clear & ~load;
    assign ones_inc   = adv & up_dn;
    assign ones_dec   = adv & ~up_dn;
    assign tens_inc   = ones_inc & ones_wrap;
    assign tens_dec   = ones_dec & ones_wrap;
    assign ld_clamped = clamp_load(load_val);

    // Ones rolls at MAX_ONES only in the top decade; a down wrap from 00 reloads MAX_ONES
    always_comb begin
        ones_wrap_at = BCD_MAX;
        if (up_dn && tens == MT)
            ones_wrap_at = MO;
        else if (!up_dn && tens == 4'd0)
            ones_wrap_at = MO;
    end

    bcd_digit u_ones (
        .CLK     (CLK),
        .rst_n   (rst_n),
        .inc     (ones_inc),
        .dec     (ones_dec),
        .ld      (load),
        .clr     (clear),
        .ld_val  (ld_clamped[3:0]),
        .wrap_at (ones_wrap_at),
`ifdef SEG_DECODE_EN
        .seg     (seg_ones),
`endif
        .digit   (ones),
        .wrap    (ones_wrap)
    );

    bcd_digit u_tens (
        .CLK     (CLK),
        .rst_n   (rst_n),
        .inc     (tens_inc),
        .dec     (tens_dec),
        .ld      (load),
        .clr     (clear),
        .ld_val  (ld_clamped[7:4]),
        .wrap_at (MT),
`ifdef SEG_DECODE_EN
        .seg     (seg_tens),
`endif
        .digit   (tens),
        .wrap    (tens_wrap)
    );

    assign count = {tens, ones};

    // tens only steps when ones wraps, so a tens wrap is a full-counter wrap
    always_ff @(posedge CLK or negedge rst_n) begin
        if (!rst_n)
            carry <= 1'b0;
        else
            carry <= tens_wrap;
    end

endmodule
